// File: rtl/wb_xbar_n.sv
// Single-master Wishbone classic interconnect, N slaves by mask/base decode; WB_XBAR_TIMEOUT_EN adds a bus-hang timer.
// Latency: 1 cycle registered decode, then ack/err/read data pass combinationally from the selected slave.
// Backpressure: master waits until the selected slave acks/errs (or the timer expires); a decode miss errors after 1 cycle.
module wb_xbar_n #(
    parameter int                     N_SLAVES = 3,
    parameter int                     AW       = 32,
    parameter logic [N_SLAVES*AW-1:0] SLV_BASE = {32'hA000_0000, 32'hF000_0000, 32'h9000_0000},
    parameter logic [N_SLAVES*AW-1:0] SLV_MASK = {32'hF000_0000, 32'hFF00_0000, 32'hF000_0000},
    parameter int                     TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [AW-1:0]            m_adr_i,
    input  logic [31:0]              m_dat_i,
    output logic [31:0]              m_dat_o,
    input  logic                     m_we_i,
    input  logic [3:0]               m_sel_i,
    input  logic                     m_stb_i,
    input  logic                     m_cyc_i,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic [N_SLAVES*AW-1:0]   s_adr_o,
    output logic [N_SLAVES*32-1:0]   s_dat_o,
    input  logic [N_SLAVES*32-1:0]   s_dat_i,
    output logic [N_SLAVES-1:0]      s_we_o,
    output logic [N_SLAVES*4-1:0]    s_sel_o,
    output logic [N_SLAVES-1:0]      s_stb_o,
    output logic [N_SLAVES-1:0]      s_cyc_o,
    input  logic [N_SLAVES-1:0]      s_ack_i,
    input  logic [N_SLAVES-1:0]      s_err_i
);

    if (N_SLAVES < 1 || N_SLAVES > 8) begin : g_bad_n_slaves
        $error("wb_xbar_n: N_SLAVES must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_xbar_n: TIMEOUT must be 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic [N_SLAVES-1:0] hit_first;
    logic                sel_ack, sel_err;
    logic [31:0]         sel_dat;

    // Request fields go to every slave; only stb/cyc are steered.
    assign s_adr_o = {N_SLAVES{m_adr_i}};
    assign s_dat_o = {N_SLAVES{m_dat_i}};
    assign s_we_o  = {N_SLAVES{m_we_i}};
    assign s_sel_o = {N_SLAVES{m_sel_i}};

    // Scan from the top so the lowest hitting index is the one left standing.
    always_comb begin
        hit_first = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_adr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit_first    = '0;
                hit_first[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_ack = sel_ack | s_ack_i[i];
                sel_err = sel_err | s_err_i[i];
                sel_dat = sel_dat | s_dat_i[i*32 +: 32];
            end
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    // timer_q counts completed ACTIVE cycles; the cycle where it reads TIMEOUT-1 is the last one allowed.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] timer_q;
    logic        timeout_hit;

    assign timeout_hit = (timer_q == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            timer_q <= '0;
        end else if (state_q != ST_ACTIVE) begin
            timer_q <= '0;
        end else if (!(sel_ack || sel_err)) begin
            timer_q <= timer_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        s_stb_o = '0;
        s_cyc_o = '0;
        m_ack_o = 1'b0;
        m_err_o = 1'b0;
        m_dat_o = '0;
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (m_cyc_i && m_stb_i) begin
                    if (|hit_first) begin
                        sel_d   = hit_first;
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                s_stb_o = sel_q & {N_SLAVES{m_stb_i}};
                s_cyc_o = sel_q & {N_SLAVES{m_cyc_i}};
                if (!m_cyc_i) begin
                    // Master abandoned the cycle: drop it without forwarding anything.
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end else begin
                    m_err_o = sel_err;
                    m_ack_o = sel_ack & ~sel_err;
                    m_dat_o = sel_dat;
                    if (sel_ack || sel_err) begin
                        state_d = ST_IDLE;
                        sel_d   = '0;
`ifdef WB_XBAR_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state_d = ST_ERR;
                        sel_d   = '0;
`endif
                    end
                end
            end
            ST_ERR: begin
                m_err_o = 1'b1;
                state_d = ST_IDLE;
                sel_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_xbar_n.sv
// Randomised scoreboard bench for wb_xbar_n: a decode/response model predicts each master response,
// a monitor pops predictions whenever the master side sees ack or err.
module tb_wb_xbar_n;
    localparam int NS = 3;
    localparam int AW = 32;
`ifdef WB_XBAR_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif
    localparam logic [31:0] REF_BASE [NS] = '{32'h9000_0000, 32'hF000_0000, 32'hA000_0000};
    localparam logic [31:0] REF_MASK [NS] = '{32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic              clk;
    logic              rstn;
    logic [AW-1:0]     m_adr_i;
    logic [31:0]       m_dat_i;
    logic [31:0]       m_dat_o;
    logic              m_we_i;
    logic [3:0]        m_sel_i;
    logic              m_stb_i;
    logic              m_cyc_i;
    logic              m_ack_o;
    logic              m_err_o;
    logic [NS*AW-1:0]  s_adr_o;
    logic [NS*32-1:0]  s_dat_o;
    logic [NS*32-1:0]  s_dat_i;
    logic [NS-1:0]     s_we_o;
    logic [NS*4-1:0]   s_sel_o;
    logic [NS-1:0]     s_stb_o;
    logic [NS-1:0]     s_cyc_o;
    logic [NS-1:0]     s_ack_i;
    logic [NS-1:0]     s_err_i;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    wb_xbar_n #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: first slave whose masked address equals its base, -1 on a miss.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & REF_MASK[i]) == REF_BASE[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_adr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 4))
            0: a[31:28] = 4'h9;
            1: a[31:24] = 8'hF0;
            2: a[31:28] = 4'hA;
            3: a[31:24] = 8'hF1 + 8'($urandom_range(0, 14));
            default: ;
        endcase
        return a;
    endfunction

    // Random traffic on every slave outside tmask; the targeted slave answers only when resp is set.
    task automatic drive_slaves(input logic [NS-1:0] tmask, input bit resp, input bit ack,
                                input bit err, input logic [31:0] rdat);
        s_dat_i = {$urandom, $urandom, $urandom};
        s_ack_i = NS'($urandom) & ~tmask;
        s_err_i = NS'($urandom & $urandom) & ~tmask;
        for (int i = 0; i < NS; i++) begin
            if (tmask[i]) begin
                s_ack_i[i] = resp && ack;
                s_err_i[i] = resp && err;
                if (resp) s_dat_i[i*32 +: 32] = rdat;
            end
        end
    endtask

    // kind: 0 ack, 1 err, 2 ack+err together, 3 never answer. dly: cycles the slave waits after first strobe.
    task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, input int kind, input int dly, input logic [31:0] rdat);
        int            tgt, exp_lat, budget, seen, lat;
        bit            got, err_state;
        logic [NS-1:0] tmask;
        resp_t         e;
        tgt   = ref_decode(adr);
        tmask = '0;
        if (tgt >= 0) tmask[tgt] = 1'b1;
        exp_lat   = 0;
        err_state = 1'b0;
        e.err     = 1'b1;
        e.dat     = '0;
        if (tgt < 0) begin
            exp_lat   = 1;
            err_state = 1'b1;
        end else begin
            if (kind != 3) begin
                exp_lat = 2 + dly;
                e.err   = (kind != 0);
                e.dat   = rdat;
            end
`ifdef WB_XBAR_TIMEOUT_EN
            if (kind == 3 || exp_lat > TB_TIMEOUT) begin
                exp_lat   = TB_TIMEOUT + 1;
                e.err     = 1'b1;
                err_state = 1'b1;
            end
`endif
        end
        if (exp_lat != 0) exp_q.push_back(e);
        budget = (exp_lat != 0) ? exp_lat + 4 : 1000;

        @(posedge clk); #1;
        m_adr_i = adr; m_dat_i = dat; m_we_i = we; m_sel_i = sel;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        drive_slaves(tmask, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("decode_latency", s_stb_o, '0);
        chk("broadcast", {s_adr_o, s_dat_o, s_sel_o, s_we_o},
            {{NS{adr}}, {NS{dat}}, {NS{sel}}, {NS{we}}});

        seen = -1;
        got  = 1'b0;
        lat  = 0;
        for (int c = 1; c <= budget && !got; c++) begin
            @(posedge clk); #1;
            drive_slaves(tmask, (kind != 3) && (seen == dly), (kind == 0 || kind == 2), (kind != 0), rdat);
            @(negedge clk);
            if (c == 1) begin
                chk("stb_select", s_stb_o, tmask);
                chk("cyc_select", s_cyc_o, tmask);
            end
            if (m_ack_o || m_err_o) begin
                got = 1'b1;
                lat = c;
                if (err_state) chk("err_strobes_low", {s_stb_o, s_cyc_o}, '0);
            end
            if (tgt >= 0 && s_stb_o[tgt]) seen++;
        end
        if (exp_lat != 0) chk("resp_latency", lat, exp_lat);
        else              chk("hang_no_resp", got, 0);

        @(posedge clk); #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        drive_slaves(tmask, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("release", {s_stb_o, s_cyc_o, m_ack_o, m_err_o}, '0);
    endtask

    // Start an access, then either reset or drop cyc mid-transfer and throw a late ack at the old slave.
    task automatic abort_xfer(input logic [31:0] adr, input bit use_reset);
        logic [NS-1:0] tmask;
        int            tgt;
        tgt   = ref_decode(adr);
        tmask = '0;
        if (tgt >= 0) tmask[tgt] = 1'b1;
        @(posedge clk); #1;
        m_adr_i = adr; m_we_i = 1'b0; m_sel_i = 4'hF; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        drive_slaves(tmask, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            drive_slaves(tmask, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        @(negedge clk);
        chk("abort_active_stb", s_stb_o, tmask);
        @(posedge clk); #1;
        if (use_reset) rstn = 1'b0;
        else begin m_cyc_i = 1'b0; m_stb_i = 1'b0; end
        drive_slaves(tmask, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        drive_slaves(tmask, 1'b1, 1'b1, 1'b0, 32'hBAD0_0001);
        @(negedge clk);
        chk("abort_strobes", {s_stb_o, s_cyc_o}, '0);
        chk("late_ack_1", {m_ack_o, m_err_o}, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        drive_slaves(tmask, 1'b1, 1'b1, 1'b0, 32'hBAD0_0002);
        @(negedge clk);
        chk("late_ack_2", {m_ack_o, m_err_o, m_dat_o}, '0);
        @(posedge clk); #1;
        drive_slaves(tmask, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: every master-side response must match the oldest outstanding prediction.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (m_ack_o === 1'b1 || m_err_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {m_ack_o, m_err_o}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", m_err_o, e.err);
                    chk("resp_ack", m_ack_o, !e.err);
                    if (!e.err) chk("resp_data", m_dat_o, e.dat);
                end
            end
        end
    end

    initial begin
        int k, r;
        rstn = 1'b0;
        m_adr_i = 32'h9000_0000; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = 4'h0;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        s_dat_i = '0; s_ack_i = '0; s_err_i = '0;
        repeat (3) begin
            @(posedge clk); #1;
            drive_slaves('0, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk("reset_outputs", {s_stb_o, s_cyc_o, m_ack_o, m_err_o, m_dat_o}, '0);
        end
        @(posedge clk); #1;
        rstn = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0;
        drive_slaves('0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("idle_after_reset", {s_stb_o, m_ack_o, m_err_o}, '0);

        access(32'h9000_0010, 1'b0, 32'h0, 4'hF, 0, 1, 32'hDEAD_BEEF);
        access(32'hF000_0004, 1'b1, 32'h0000_1234, 4'b0011, 0, 0, 32'h0);
        access(32'h0000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0);
        access(32'hA000_0000, 1'b0, 32'h0, 4'hF, 2, 1, 32'h5555_AAAA);
        access(32'hA000_0100, 1'b1, 32'hCAFE_0000, 4'hC, 1, 0, 32'h0);
        access(32'h9000_0000, 1'b0, 32'h0, 4'hF, 3, 0, 32'h0);
`ifdef WB_XBAR_TIMEOUT_EN
        access(32'h9000_0020, 1'b0, 32'h0, 4'hF, 0, TB_TIMEOUT - 2, 32'h0BAD_F00D);
        access(32'hF000_0020, 1'b0, 32'h0, 4'hF, 0, TB_TIMEOUT - 1, 32'h1111_2222);
`endif
        abort_xfer(32'h9000_0040, 1'b1);
        access(32'h9000_0044, 1'b0, 32'h0, 4'hF, 0, 0, 32'h7777_0001);
        abort_xfer(32'hA000_0040, 1'b0);
        access(32'hA000_0044, 1'b0, 32'h0, 4'hF, 0, 2, 32'h7777_0002);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            k = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
`ifdef WB_XBAR_TIMEOUT_EN
            if (r == 9) k = 3;
`endif
            access(rand_adr(), 1'($urandom), $urandom, 4'($urandom), k, $urandom_range(0, 5), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
